alu_cmd_sequencer: RTL and testbench

Sequences single operations through the 4-bit ALU/decoder datapath. It accepts one command (X, Y, M, Control) per valid/ready handshake and latches the operands onto the ALU inputs. It then strobes the ALU, waits a fixed latency and captures the 8-bit result into a held register that drives the 7-segment display path. It sits between the board input logic (switches/buttons or a test host) and the ALU; the display decoder reads `result`/`result_valid`.

---
 rtl/alu_cmd_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 4-bit ALU/decoder datapath: latches one command per
// handshake, strobes the ALU, waits ALU_LAT cycles and holds the captured result.
module alu_cmd_sequencer #(
  parameter int unsigned ALU_LAT = 2,
  parameter int unsigned NUM_OPS = 10
) (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_x,
  input  logic [3:0] cmd_y,
  input  logic [3:0] cmd_m,
  input  logic       cmd_control,
  output logic [3:0] alu_x,
  output logic [3:0] alu_y,
  output logic [3:0] alu_m,
  output logic       alu_control,
  output logic       alu_en,
  input  logic [7:0] alu_result,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       done,
  output logic       busy,
  output logic       err,
  output logic [7:0] op_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam logic [3:0] LAT_RELOAD = 4'(ALU_LAT - 1);
  localparam logic [7:0] ILLEGAL_CODE = 8'hEE;

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] aluX_q, aluX_d;
  logic [3:0] aluY_q, aluY_d;
  logic [3:0] aluM_q, aluM_d;
  logic       aluControl_q, aluControl_d;
  logic       aluEn_q, aluEn_d;
  logic [7:0] result_q, result_d;
  logic       resultValid_q, resultValid_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] opCount_q, opCount_d;
  logic       cmdLegal;

  assign cmdLegal = ({28'd0, cmd_m} < NUM_OPS);

  // An illegal opcode is answered in IDLE at the accept edge and never reaches the ALU.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    aluX_d        = aluX_q;
    aluY_d        = aluY_q;
    aluM_d        = aluM_q;
    aluControl_d  = aluControl_q;
    aluEn_d       = 1'b0;
    result_d      = result_q;
    resultValid_d = resultValid_q;
    done_d        = 1'b0;
    err_d         = err_q;
    opCount_d     = opCount_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          resultValid_d = 1'b0;
          err_d         = 1'b0;
          if (cmdLegal) begin
            aluX_d       = cmd_x;
            aluY_d       = cmd_y;
            aluM_d       = cmd_m;
            aluControl_d = cmd_control;
            aluEn_d      = 1'b1;
            state_d      = ISSUE;
          end else begin
            err_d         = 1'b1;
            result_d      = ILLEGAL_CODE;
            resultValid_d = 1'b1;
            done_d        = 1'b1;
          end
        end
      end
      ISSUE: begin
        cnt_d   = LAT_RELOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          result_d      = alu_result;
          resultValid_d = 1'b1;
          done_d        = 1'b1;
          opCount_d     = opCount_q + 8'd1;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      aluX_q        <= 4'd0;
      aluY_q        <= 4'd0;
      aluM_q        <= 4'd0;
      aluControl_q  <= 1'b0;
      aluEn_q       <= 1'b0;
      result_q      <= 8'd0;
      resultValid_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      opCount_q     <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      aluX_q        <= aluX_d;
      aluY_q        <= aluY_d;
      aluM_q        <= aluM_d;
      aluControl_q  <= aluControl_d;
      aluEn_q       <= aluEn_d;
      result_q      <= result_d;
      resultValid_q <= resultValid_d;
      done_q        <= done_d;
      err_q         <= err_d;
      opCount_q     <= opCount_d;
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign alu_x        = aluX_q;
  assign alu_y        = aluY_q;
  assign alu_m        = aluM_q;
  assign alu_control  = aluControl_q;
  assign alu_en       = aluEn_q;
  assign result       = result_q;
  assign result_valid = resultValid_q;
  assign done         = done_q;
  assign err          = err_q;
  assign op_count     = opCount_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: random and directed commands against a
// reference model, plus latency checks on ALU_LAT=1 and ALU_LAT=15 instances.
module tb_alu_cmd_sequencer;

  localparam int LAT = 2;

  typedef struct {
    logic [7:0]  res;
    logic        e;
    logic [7:0]  oc;
    logic [12:0] regs;
    int          doneCycle;
  } exp_t;

  logic        clock_100Mhz = 1'b0;
  logic        reset;
  logic        cmdValid, cmdReady;
  logic [3:0]  cmdX, cmdY, cmdM;
  logic        cmdControl;
  logic [3:0]  aluX, aluY, aluM;
  logic        aluControl, aluEn;
  logic [7:0]  aluResult, result, opCount;
  logic        resultValid, done, busy, err;

  logic        v1, r1, ac1, en1, rv1, done1, busy1, err1;
  logic [3:0]  ax1, ay1, am1;
  logic [7:0]  ar1, result1, oc1;
  logic        v15, r15, ac15, en15, rv15, done15, busy15, err15;
  logic [3:0]  ax15, ay15, am15;
  logic [7:0]  ar15, result15, oc15;

  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  exp_t        sbQ[$];
  exp_t        monE;
  logic [7:0]  mOpCount;
  logic [12:0] mRegs;
  logic [12:0] issueRegs;
  int          expIssueCycle;

  always #5 clock_100Mhz = ~clock_100Mhz;
  always @(posedge clock_100Mhz) cycle <= cycle + 1;

  // Stand-in ALU: M=0 add, M=1 subtract, remaining opcodes simple bit operations.
  function automatic logic [7:0] aluModel(input logic [3:0] x, input logic [3:0] y,
                                          input logic [3:0] m, input logic c);
    logic [7:0] r;
    case (m)
      4'd0: r = {4'h0, x} + {4'h0, y};
      4'd1: r = {4'h0, 4'(x - y)};
      4'd2: r = {4'h0, x & y};
      4'd3: r = {4'h0, x | y};
      4'd4: r = {4'h0, x ^ y};
      4'd5: r = {4'h0, ~x};
      4'd6: r = {x, y};
      4'd7: r = {y, x};
      4'd8: r = {4'h0, x} * {4'h0, y};
      4'd9: r = {4'h0, x} << y[1:0];
      default: r = 8'h00;
    endcase
    if (c) r = r ^ 8'h80;
    return r;
  endfunction

  assign aluResult = aluModel(aluX, aluY, aluM, aluControl);
  assign ar1       = aluModel(ax1, ay1, am1, ac1);
  assign ar15      = aluModel(ax15, ay15, am15, ac15);

  alu_cmd_sequencer #(.ALU_LAT(LAT), .NUM_OPS(10)) dut (
    .clock_100Mhz(clock_100Mhz), .reset(reset),
    .cmd_valid(cmdValid), .cmd_ready(cmdReady),
    .cmd_x(cmdX), .cmd_y(cmdY), .cmd_m(cmdM), .cmd_control(cmdControl),
    .alu_x(aluX), .alu_y(aluY), .alu_m(aluM), .alu_control(aluControl),
    .alu_en(aluEn), .alu_result(aluResult),
    .result(result), .result_valid(resultValid), .done(done),
    .busy(busy), .err(err), .op_count(opCount)
  );

  alu_cmd_sequencer #(.ALU_LAT(1), .NUM_OPS(10)) dutLat1 (
    .clock_100Mhz(clock_100Mhz), .reset(reset),
    .cmd_valid(v1), .cmd_ready(r1),
    .cmd_x(cmdX), .cmd_y(cmdY), .cmd_m(cmdM), .cmd_control(cmdControl),
    .alu_x(ax1), .alu_y(ay1), .alu_m(am1), .alu_control(ac1),
    .alu_en(en1), .alu_result(ar1),
    .result(result1), .result_valid(rv1), .done(done1),
    .busy(busy1), .err(err1), .op_count(oc1)
  );

  alu_cmd_sequencer #(.ALU_LAT(15), .NUM_OPS(10)) dutLat15 (
    .clock_100Mhz(clock_100Mhz), .reset(reset),
    .cmd_valid(v15), .cmd_ready(r15),
    .cmd_x(cmdX), .cmd_y(cmdY), .cmd_m(cmdM), .cmd_control(cmdControl),
    .alu_x(ax15), .alu_y(ay15), .alu_m(am15), .alu_control(ac15),
    .alu_en(en15), .alu_result(ar15),
    .result(result15), .result_valid(rv15), .done(done15),
    .busy(busy15), .err(err15), .op_count(oc15)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Hold valid until accepted; operands are scrambled while the DUT is busy.
  task automatic applyStimulus(input logic [3:0] x, input logic [3:0] y,
                               input logic [3:0] m, input logic c);
    int waited = 0;
    @(negedge clock_100Mhz);
    while (!cmdReady && waited < 64) begin
      cmdValid   = 1'b1;
      cmdX       = 4'($urandom);
      cmdY       = 4'($urandom);
      cmdM       = 4'($urandom);
      cmdControl = 1'($urandom);
      waited++;
      @(negedge clock_100Mhz);
    end
    if (!cmdReady) begin
      checkOutput("readyTimeout", 32'(cmdReady), 32'd1);
      return;
    end
    cmdValid   = 1'b1;
    cmdX       = x;
    cmdY       = y;
    cmdM       = m;
    cmdControl = c;
    if (m < 4'd10) begin
      mRegs         = {x, y, m, c};
      issueRegs     = mRegs;
      mOpCount      = mOpCount + 8'd1;
      expIssueCycle = cycle + 1;
      sbQ.push_back('{aluModel(x, y, m, c), 1'b0, mOpCount, mRegs, cycle + 1 + LAT + 1});
    end else begin
      sbQ.push_back('{8'hEE, 1'b1, mOpCount, mRegs, cycle + 1});
    end
    @(posedge clock_100Mhz);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock_100Mhz);
      cmdValid = 1'b0;
      cmdX     = 4'($urandom);
      cmdM     = 4'($urandom);
    end
  endtask

  task automatic doReset();
    @(negedge clock_100Mhz);
    reset         = 1'b1;
    cmdValid      = 1'b1;
    sbQ.delete();
    mOpCount      = 8'd0;
    mRegs         = 13'd0;
    issueRegs     = 13'd0;
    expIssueCycle = -1;
    @(negedge clock_100Mhz);
    checkOutput("resetReady", 32'(cmdReady), 32'd1);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetResult", 32'(result), 32'd0);
    checkOutput("resetResultValid", 32'(resultValid), 32'd0);
    checkOutput("resetOpCount", 32'(opCount), 32'd0);
    checkOutput("resetDoneErr", 32'({done, err, aluEn}), 32'd0);
    checkOutput("resetAluRegs", 32'({aluX, aluY, aluM, aluControl}), 32'd0);
    reset    = 1'b0;
    cmdValid = 1'b0;
  endtask

  task automatic latencyCheck(input int lat);
    int start;
    int waited = 0;
    @(negedge clock_100Mhz);
    cmdValid = 1'b0;
    cmdX = 4'h9; cmdY = 4'h8; cmdM = 4'h0; cmdControl = 1'b0;
    if (lat == 1) v1 = 1'b1; else v15 = 1'b1;
    start = cycle + 1;
    @(negedge clock_100Mhz);
    v1 = 1'b0; v15 = 1'b0;
    while (!(lat == 1 ? done1 : done15) && waited < 40) begin
      @(negedge clock_100Mhz);
      waited++;
    end
    checkOutput(lat == 1 ? "lat1DoneEdges" : "lat15DoneEdges", 32'(cycle - start), 32'(lat + 1));
    checkOutput(lat == 1 ? "lat1Result" : "lat15Result",
                32'(lat == 1 ? result1 : result15), 32'h11);
  endtask

  // Monitor: alu_en timing every cycle, scoreboard pop on every done.
  always @(negedge clock_100Mhz) begin
    if (!reset) begin
      if (aluEn || cycle == expIssueCycle) begin
        checkOutput("aluEnTiming", 32'(aluEn), 32'(cycle == expIssueCycle));
        checkOutput("aluOperands", 32'({aluX, aluY, aluM, aluControl}), 32'(issueRegs));
      end
      if (done) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedDone", 32'(done), 32'd0);
        end else begin
          monE = sbQ.pop_front();
          checkOutput("doneCycle", 32'(cycle), 32'(monE.doneCycle));
          checkOutput("result", 32'(result), 32'(monE.res));
          checkOutput("err", 32'(err), 32'(monE.e));
          checkOutput("resultValid", 32'(resultValid), 32'd1);
          checkOutput("opCount", 32'(opCount), 32'(monE.oc));
          checkOutput("aluRegsHeld", 32'({aluX, aluY, aluM, aluControl}), 32'(monE.regs));
          checkOutput("readyWithDone", 32'(cmdReady), 32'd1);
        end
      end else if (sbQ.size() != 0 && cycle > sbQ[0].doneCycle) begin
        checkOutput("missingDone", 32'(done), 32'd1);
        void'(sbQ.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; cmdValid = 1'b1; v1 = 1'b0; v15 = 1'b0;
    cmdX = 4'h0; cmdY = 4'h0; cmdM = 4'h0; cmdControl = 1'b0;
    mOpCount = 8'd0; mRegs = 13'd0; issueRegs = 13'd0; expIssueCycle = -1;
    doReset();

    applyStimulus(4'h9, 4'h8, 4'h0, 1'b0);
    idle(6);
    checkOutput("firstResult", 32'(result), 32'h11);
    checkOutput("firstOpCount", 32'(opCount), 32'd1);

    applyStimulus(4'h3, 4'h5, 4'hC, 1'b1);
    idle(3);
    checkOutput("illegalHoldResult", 32'(result), 32'hEE);
    checkOutput("illegalHoldErr", 32'(err), 32'd1);

    applyStimulus(4'h2, 4'h7, 4'h1, 1'b0);
    applyStimulus(4'hF, 4'hF, 4'h8, 1'b1);
    applyStimulus(4'hA, 4'h6, 4'h4, 1'b0);
    idle(8);
    checkOutput("backToBackCount", 32'(opCount), 32'd4);

    applyStimulus(4'h5, 4'h4, 4'h0, 1'b0);
    idle(1);
    doReset();
    idle(6);
    applyStimulus(4'h1, 4'h2, 4'h0, 1'b0);
    idle(6);
    checkOutput("afterAbortCount", 32'(opCount), 32'd1);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(8);

    doReset();
    for (int i = 0; i < 256; i++) begin
      applyStimulus(4'($urandom), 4'($urandom), 4'($urandom_range(0, 9)), 1'($urandom));
    end
    idle(8);
    checkOutput("opCountWrap", 32'(opCount), 32'd0);

    latencyCheck(1);
    latencyCheck(15);
    idle(4);
    checkOutput("scoreboardDrained", 32'(sbQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
